// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl
//
// Bit-serial unsigned magnitude comparator. Operands are captured on a start
// handshake, then one bit pair per clock is examined MSB first through a
// single 1-bit compare stage. The walk stops at the first differing bit, or
// at bit 0 for equal operands. The result is reported on lt/eq/gt with a
// one-cycle done pulse. This trades latency for area compared with a
// full-width comparator tree, which matters for wide operands.
//
// Parameters:
//   WIDTH  operand width in bits (2 or more)
//   CW     width of nbits; derived from WIDTH and not meant to be overridden
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request; sampled only while busy is low
//   a, b   operands; captured on the accepting edge
//   busy   high while a comparison is in progress
//   done   one-cycle pulse when a new result is valid
//   lt     A < B, held until the next result
//   eq     A == B, held until the next result
//   gt     A > B, held until the next result
//   nbits  bit positions examined for the last result (1..WIDTH), held

module serial_mag_comp_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [CW-1:0]    nbits
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic [CW-1:0]    nbits_q, nbits_d;

  // The single 1-bit compare stage, shared by every bit position.
  logic bit_a, bit_b;
  logic bit_lt, bit_gt, bit_eq;

  assign bit_a  = ra_q[idx_q];
  assign bit_b  = rb_q[idx_q];
  assign bit_lt = ~bit_a & bit_b;
  assign bit_gt = bit_a & ~bit_b;
  assign bit_eq = ~(bit_a ^ bit_b);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    nbits_d = nbits_q;

    unique case (state_q)
      StIdle: begin
        // Accepting a request leaves the previous result visible.
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          idx_d   = IW'(WIDTH - 1);
          state_d = StRun;
        end
      end

      StRun: begin
        // Finish at the first differing bit, or at bit 0 when all bits match.
        // idx therefore never wraps below zero.
        if (!bit_eq || (idx_q == '0)) begin
          done_d  = 1'b1;
          lt_d    = bit_lt;
          gt_d    = bit_gt;
          eq_d    = bit_eq;
          // Bits WIDTH-1 down to idx inclusive have been examined.
          nbits_d = CW'(WIDTH) - CW'(idx_q);
          state_d = StIdle;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers. Reset discards any in-flight comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      nbits_q <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      nbits_q <= nbits_d;
    end
  end

  // All outputs come straight from registers.
  // busy drops on the same edge that raises done.
  assign busy  = (state_q == StRun);
  assign done  = done_q;
  assign lt    = lt_q;
  assign eq    = eq_q;
  assign gt    = gt_q;
  assign nbits = nbits_q;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Directed and random bench for serial_mag_comp_ctrl (WIDTH = 8).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_serial_mag_comp_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a, b;
  logic          busy, done, lt, eq, gt;
  logic [CW-1:0] nbits;

  int n_chk  = 0;
  int n_fail = 0;

  serial_mag_comp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .lt    (lt),
    .eq    (eq),
    .gt    (gt),
    .nbits (nbits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one comparison after an idle gap and check its result.
  // exp_res is {lt, eq, gt}. nbits always equals the latency.
  task automatic run_cmp(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2:0] exp_res, input int exp_lat, input int gap);
    int cyc;
    repeat (gap) @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Changing the operands after the accepting edge must have no effect.
    a     = ~av;
    b     = bv ^ 8'h5A;
    chk({tag, " busy after accept"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < W + 4);
    chk({tag, " done seen"}, {31'd0, done}, 32'd1);
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " busy in done cycle"}, {31'd0, busy}, 32'd0);
    chk({tag, " lt/eq/gt"}, {29'd0, lt, eq, gt}, {29'd0, exp_res});
    chk({tag, " nbits"}, {28'd0, nbits}, exp_lat);
    @(negedge clk);
    chk({tag, " done single pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int          cyc;
    logic        bad;
    logic [W-1:0] ra, rb;
    logic [2:0]  er;
    int          el;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state
    @(negedge clk);
    chk("reset outputs", {23'd0, busy, done, lt, eq, gt, nbits}, 32'd0);
    rst = 1'b0;

    // Idle with start low for 5 cycles
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if ({busy, done, lt, eq, gt, nbits} !== '0) bad = 1'b1;
    end
    chk("idle outputs stay zero", {31'd0, bad}, 32'd0);

    // Directed comparisons. exp_res is {lt, eq, gt}.
    run_cmp("A5vs25", 8'hA5, 8'h25, 3'b001, 1, 0);
    run_cmp("3Cvs3D", 8'h3C, 8'h3D, 3'b100, 8, 1);
    run_cmp("FFvsFF", 8'hFF, 8'hFF, 3'b010, 8, 2);
    run_cmp("00vs00", 8'h00, 8'h00, 3'b010, 8, 0);
    run_cmp("7Fvs80", 8'h7F, 8'h80, 3'b100, 1, 0);
    run_cmp("12vs16", 8'h12, 8'h16, 3'b100, 6, 0);

    // Hold start high with changing operands while busy.
    // 10 vs 08 differs first at bit 4, so the result is gt after 4 cycles.
    a     = 8'h10;
    b     = 8'h08;
    start = 1'b1;
    @(negedge clk);
    cyc = 0;
    do begin
      a = 8'hF0 ^ 8'(cyc);
      b = 8'h0F ^ 8'(cyc);
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < W + 4);
    chk("hold-start latency", cyc, 4);
    chk("hold-start lt/eq/gt", {29'd0, lt, eq, gt}, 32'd1);
    chk("hold-start nbits", {28'd0, nbits}, 32'd4);
    chk("hold-start busy in done cycle", {31'd0, busy}, 32'd0);
    // start is still high in the done cycle, so the next edge accepts.
    a = 8'h00;
    b = 8'h80;
    @(negedge clk);
    start = 1'b0;
    chk("back-to-back accept", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("back-to-back done", {31'd0, done}, 32'd1);
    chk("back-to-back lt/eq/gt", {29'd0, lt, eq, gt}, 32'd4);
    chk("back-to-back nbits", {28'd0, nbits}, 32'd1);

    // Reset during RUN
    a     = 8'h01;
    b     = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-run reset outputs", {23'd0, busy, done, lt, eq, gt, nbits}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("no done after reset", {31'd0, bad}, 32'd0);
    run_cmp("after reset 01vs00", 8'h01, 8'h00, 3'b001, 8, 0);

    // Random sweep with a small reference model
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (n % 4 == 0) rb = ra ^ (8'h01 << $urandom_range(0, 7));
      if (n % 16 == 5) rb = ra;
      er = {ra < rb, ra == rb, ra > rb};
      el = W;
      for (int i = 0; i < W; i++) begin
        if (ra[i] != rb[i]) el = W - i;
      end
      run_cmp("random", ra, rb, er, el, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
